// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_port_arbiter_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_A = 2'b01,
    BUSY_B = 2'b10
  } state_t;

  // Address mux select values
  localparam logic SEL_FETCH = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

  // Default parameter values
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF      = 64;
  localparam int CNT_W_DEF        = 7;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int W   = 7,
  parameter int MAX = 127
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count up while enabled, hold at MAX, zero on reset or clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the shared memory port: fetch (A) vs data (B).
// Request/complete handshake: a requester holds req_x high until it sees
// done_x or err_x; the selection and write controls stay frozen from grant
// until that pulse, and mem_ready is only honoured while a transaction is open.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        we_b,
  input  logic [31:0] wdata_b,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mux_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        done_a,
  output logic        done_b,
  output logic        err_a,
  output logic        err_b,
  output logic [31:0] rdata,
  output logic [1:0]  state_dbg
);

  state_t      state_q, state_d;
  logic        mux_sel_d, mem_req_d, mem_we_d;
  logic [31:0] mem_wdata_d, rdata_d;
  logic        done_a_d, done_b_d, err_a_d, err_b_d;

  logic [CNT_W-1:0] wait_cnt, tmo_cnt;
  logic             starve, tmo_hit, grant_a;

  assign starve    = (wait_cnt >= CNT_W'(STARVE_LIMIT));
  assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign grant_a   = (state_q == IDLE) && (state_d == BUSY_A);
  assign state_dbg = state_q;

  // Starvation counter: A waiting with its request up, cleared once served
  sat_counter #(.W(CNT_W), .MAX((1 << CNT_W) - 1)) u_wait_cnt (
    .clk   (Clk),
    .rst_n (Reset),
    .en    (req_a),
    .clr   (!req_a || grant_a || (state_q == BUSY_A)),
    .cnt   (wait_cnt)
  );

  // Timeout counter: counts BUSY cycles, restarts in IDLE
  sat_counter #(.W(CNT_W), .MAX((1 << CNT_W) - 1)) u_tmo_cnt (
    .clk   (Clk),
    .rst_n (Reset),
    .en    (state_q != IDLE),
    .clr   (state_q == IDLE),
    .cnt   (tmo_cnt)
  );

  // Next-state and next-output logic; everything holds unless changed
  always_comb begin
    state_d     = state_q;
    mux_sel_d   = mux_sel;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_wdata_d = mem_wdata;
    rdata_d     = rdata;
    done_a_d    = 1'b0;
    done_b_d    = 1'b0;
    err_a_d     = 1'b0;
    err_b_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_b && !(req_a && starve)) begin
          state_d     = BUSY_B;
          mux_sel_d   = SEL_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = we_b;
          mem_wdata_d = wdata_b;
        end else if (req_a) begin
          state_d   = BUSY_A;
          mux_sel_d = SEL_FETCH;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b0;
        end
      end
      BUSY_A, BUSY_B: begin
        // mem_ready takes priority over a coincident timeout
        if (mem_ready) begin
          rdata_d   = mem_rdata;
          done_a_d  = (state_q == BUSY_A);
          done_b_d  = (state_q == BUSY_B);
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = IDLE;
        end else if (tmo_hit) begin
          err_a_d   = (state_q == BUSY_A);
          err_b_d   = (state_q == BUSY_B);
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      mux_sel   <= SEL_FETCH;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rdata     <= '0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      err_a     <= 1'b0;
      err_b     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mux_sel   <= mux_sel_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_wdata <= mem_wdata_d;
      rdata     <= rdata_d;
      done_a    <= done_a_d;
      done_b    <= done_b_d;
      err_a     <= err_a_d;
      err_b     <= err_b_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_a, req_b, we_b, mem_ready;
  logic [31:0] wdata_b, mem_rdata;
  logic        mux_sel, mem_req, mem_we;
  logic [31:0] mem_wdata, rdata;
  logic        done_a, done_b, err_a, err_b;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int busy     = 0;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_A    = 2'b01;
  localparam logic [1:0] S_B    = 2'b10;

  mem_port_arbiter dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_a     (req_a),
    .req_b     (req_b),
    .we_b      (we_b),
    .wdata_b   (wdata_b),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mux_sel   (mux_sel),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .done_a    (done_a),
    .done_b    (done_b),
    .err_a     (err_a),
    .err_b     (err_b),
    .rdata     (rdata),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 Clk = ~Clk;

  // Advance one edge and settle before sampling or driving
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    req_a = 0; req_b = 0; we_b = 0; wdata_b = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  initial begin
    idle_inputs();
    Reset = 0;
    tick(); tick();
    Reset = 1;
    tick();
    // Reset state
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    check("rst_mux_sel", 32'(mux_sel), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_pulses", {28'd0, done_a, done_b, err_a, err_b}, 0);

    // Fetch read, mem_ready on third BUSY cycle
    req_a = 1;
    tick();
    check("a_grant_req", 32'(mem_req), 1);
    check("a_grant_sel", 32'(mux_sel), 0);
    check("a_grant_state", 32'(state_dbg), 32'(S_A));
    check("a_grant_we", 32'(mem_we), 0);
    tick();
    check("a_busy2_req", 32'(mem_req), 1);
    tick();
    check("a_busy3_req", 32'(mem_req), 1);
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    check("a_done", 32'(done_a), 1);
    check("a_rdata", rdata, 32'hDEADBEEF);
    check("a_done_req", 32'(mem_req), 0);
    check("a_done_state", 32'(state_dbg), 32'(S_IDLE));
    idle_inputs();
    tick();
    check("a_done_pulse", 32'(done_a), 0);
    check("a_after_req", 32'(mem_req), 0);

    // Contention: B wins twice, then starved A wins
    req_a = 1; req_b = 1; mem_ready = 1; mem_rdata = 32'h1111_2222;
    tick();
    check("c1_sel", 32'(mux_sel), 1);
    check("c1_state", 32'(state_dbg), 32'(S_B));
    tick();
    check("c1_done_b", 32'(done_b), 1);
    tick();
    check("c2_sel", 32'(mux_sel), 1);
    check("c2_state", 32'(state_dbg), 32'(S_B));
    tick();
    check("c2_done_b", 32'(done_b), 1);
    tick();
    check("c3_sel_starve", 32'(mux_sel), 0);
    check("c3_state", 32'(state_dbg), 32'(S_A));
    req_b = 0; mem_rdata = 32'h3333_4444;
    tick();
    check("c3_done_a", 32'(done_a), 1);
    check("c3_rdata", rdata, 32'h3333_4444);
    // Wait count cleared by the grant: B wins again
    req_b = 1; mem_ready = 0;
    tick();
    check("c4_sel_cleared", 32'(mux_sel), 1);
    check("c4_state", 32'(state_dbg), 32'(S_B));
    mem_ready = 1;
    tick();
    check("c4_done_b", 32'(done_b), 1);
    idle_inputs();
    tick();

    // Write: controls captured at grant and held
    req_b = 1; we_b = 1; wdata_b = 32'h0000_1234;
    tick();
    check("w_we", 32'(mem_we), 1);
    check("w_wdata", mem_wdata, 32'h0000_1234);
    check("w_sel", 32'(mux_sel), 1);
    we_b = 0; wdata_b = 32'hFFFF_FFFF;
    tick();
    check("w_we_hold", 32'(mem_we), 1);
    check("w_wdata_hold", mem_wdata, 32'h0000_1234);
    mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
    tick();
    check("w_done_b", 32'(done_b), 1);
    check("w_we_drop", 32'(mem_we), 0);
    check("w_rdata", rdata, 32'h0BAD_F00D);
    idle_inputs();
    tick();

    // Timeout on fetch with no mem_ready
    req_a = 1; mem_rdata = 32'h5555_AAAA;
    tick();
    busy = mem_req ? 1 : 0;
    for (int i = 0; i < 100 && !err_a; i++) begin
      tick();
      if (mem_req) busy++;
      if (done_a) check("to_no_done", 32'(done_a), 0);
    end
    check("to_err_a", 32'(err_a), 1);
    check("to_busy_cycles", busy, 64);
    check("to_mem_req", 32'(mem_req), 0);
    check("to_rdata_kept", rdata, 32'h0BAD_F00D);
    req_a = 0;
    tick();
    check("to_err_pulse", 32'(err_a), 0);

    // mem_ready coincident with timeout: done wins
    req_a = 1;
    tick();
    repeat (63) tick();
    check("tie_still_busy", 32'(mem_req), 1);
    mem_ready = 1; mem_rdata = 32'hCAFE_0001;
    tick();
    check("tie_done_a", 32'(done_a), 1);
    check("tie_err_a", 32'(err_a), 0);
    check("tie_rdata", rdata, 32'hCAFE_0001);
    idle_inputs();
    tick();

    // Reset during BUSY_B aborts silently
    req_b = 1;
    tick();
    check("rb_state", 32'(state_dbg), 32'(S_B));
    Reset = 0;
    tick();
    check("rb_state_idle", 32'(state_dbg), 32'(S_IDLE));
    check("rb_mem_req", 32'(mem_req), 0);
    check("rb_mux_sel", 32'(mux_sel), 0);
    check("rb_pulses", {28'd0, done_a, done_b, err_a, err_b}, 0);
    Reset = 1; req_b = 0; mem_ready = 1;
    tick();
    check("rb_ready_ignored", {28'd0, done_a, done_b, err_a, err_b}, 0);
    check("rb_idle_req", 32'(mem_req), 0);
    check("rb_idle_state", 32'(state_dbg), 32'(S_IDLE));
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
